timer_apb_sequencer: RTL and testbench

- APB master that programs and supervises the APB timer: TCNT at 0x0, TCR at 0x4, TSR at 0x8.
- A host issues a single start pulse with a period value.
- The block then runs load → clear flags → start count → poll for underflow → acknowledge, and raises done/irq.
- In auto-reload mode it re-arms and repeats. Sits between the interrupt handler logic and the timer's APB slave port.

---
 rtl/timer_apb_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_timer_apb_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_sequencer.sv
// APB master that programs the timer, polls TSR for underflow and reports done/irq.
// Optional pready watchdog and timeout port enabled by defining TIMER_SEQ_TIMEOUT_EN.
module timer_apb_sequencer #(
  parameter logic [31:0] TCNT_ADDR    = 32'h0,
  parameter logic [31:0] TCR_ADDR     = 32'h4,
  parameter logic [31:0] TSR_ADDR     = 32'h8,
  parameter logic [31:0] TCR_LOAD_VAL = 32'h80,
  parameter logic [31:0] TCR_RUN_VAL  = 32'h30,
  parameter logic [31:0] TSR_CLR_VAL  = 32'h3,
  parameter int unsigned UDF_BIT      = 1,
  parameter int unsigned POLL_GAP     = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        start,
  input  logic [31:0] period,
  input  logic        auto_reload,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        irq,
  output logic        err,
`ifdef TIMER_SEQ_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_TCNT, S_RD_TSR, S_CLR_TSR, S_WR_LOAD, S_WR_RUN,
    S_POLL_WAIT, S_POLL_RD, S_ACK, S_STOP, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]       paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [31:0]       period_q, period_d;
  logic              auto_q, auto_d, cancel_q, cancel_d;
  logic              busy_q, busy_d, done_q, done_d, irq_q, irq_d, err_q, err_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic              xfer_wr;
  logic [31:0]       xfer_addr, xfer_data;
  logic              cancel_pend;
`ifdef TIMER_SEQ_TIMEOUT_EN
  logic [7:0]        wd_q, wd_d;
  logic              timeout_q, timeout_d;
`endif

  assign cancel_pend = cancel_q | cancel;

  // Bus transfer descriptor owned by each transfer state.
  always_comb begin
    xfer_wr   = 1'b1;
    xfer_addr = TSR_ADDR;
    xfer_data = '0;
    case (state_q)
      S_WR_TCNT: begin xfer_addr = TCNT_ADDR; xfer_data = period_q; end
      S_RD_TSR,
      S_POLL_RD: xfer_wr = 1'b0;
      S_CLR_TSR,
      S_ACK:     xfer_data = TSR_CLR_VAL;
      S_WR_LOAD: begin xfer_addr = TCR_ADDR; xfer_data = TCR_LOAD_VAL; end
      S_WR_RUN:  begin xfer_addr = TCR_ADDR; xfer_data = TCR_RUN_VAL; end
      S_STOP:    xfer_addr = TCR_ADDR;
      default:   ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    period_d  = period_q;
    auto_d    = auto_q;
    cancel_d  = cancel_pend;
    done_d    = 1'b0;
    irq_d     = irq_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
`ifdef TIMER_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    if (cancel) irq_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (start) begin
          state_d  = S_WR_TCNT;
          period_d = period;
          auto_d   = auto_reload;
          irq_d    = 1'b0;
          err_d    = 1'b0;
`ifdef TIMER_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_POLL_WAIT: begin
        if (cancel_pend)          state_d = S_STOP;
        else if (cnt_q == GAP_LAST) state_d = S_POLL_RD;
        else                      cnt_d = cnt_q + GAP_W'(1);
      end
      S_ERR: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        // Idle bus cycle: launch SETUP unless a cancel diverts to STOP (ACK always finishes).
        if (!psel_q) begin
          if (cancel_pend && state_q != S_ACK && state_q != S_STOP) begin
            state_d = S_STOP;
          end else begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = xfer_wr;
            paddr_d   = xfer_addr;
            pwdata_d  = xfer_data;
`ifdef TIMER_SEQ_TIMEOUT_EN
            wd_d      = '0;
`endif
          end
        end else if (!penable_q) begin
          penable_d = 1'b1;
        end else if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pslverr) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            case (state_q)
              S_WR_TCNT: state_d = S_RD_TSR;
              S_RD_TSR:  state_d = (prdata != '0) ? S_CLR_TSR : S_WR_LOAD;
              S_CLR_TSR: state_d = S_WR_LOAD;
              S_WR_LOAD: state_d = S_WR_RUN;
              S_WR_RUN:  state_d = S_POLL_WAIT;
              S_POLL_RD: state_d = prdata[UDF_BIT] ? S_ACK : S_POLL_WAIT;
              S_ACK: begin
                done_d  = 1'b1;
                irq_d   = 1'b1;
                state_d = (cancel_pend || !auto_q) ? S_STOP : S_POLL_WAIT;
              end
              default:   state_d = S_IDLE;
            endcase
          end
        end else begin
`ifdef TIMER_SEQ_TIMEOUT_EN
          // Abort on the 255th ACCESS cycle without pready.
          if (wd_q == 8'd254) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            err_d     = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_ERR;
          end else begin
            wd_d = wd_q + 8'd1;
          end
`endif
        end
      end
    endcase

    if (state_d == S_POLL_WAIT && state_q != S_POLL_WAIT) cnt_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      period_q  <= '0;
      auto_q    <= 1'b0;
      cancel_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef TIMER_SEQ_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      period_q  <= period_d;
      auto_q    <= auto_d;
      cancel_q  <= cancel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef TIMER_SEQ_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign irq     = irq_q;
  assign err     = err_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
`ifdef TIMER_SEQ_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Directed bench for timer_apb_sequencer with a behavioural APB timer slave and transfer log.
module tb_timer_apb_sequencer;

  logic        pclk, preset_n, start, auto_reload, cancel;
  logic [31:0] period;
  logic        busy, done, irq, err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
`ifdef TIMER_SEQ_TIMEOUT_EN
  logic        timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Slave configuration and transfer log.
  int          ready_delay = 0;
  int          err_idx     = -1;
  int          xfer_idx    = 0;
  int          cur_pen     = 0;
  int          done_cnt    = 0;
  logic [31:0] rd_vals[$];
  logic        lw[64];
  logic [31:0] la[64], ld[64];
  int          lp[64];
  int          n_log = 0;

  timer_apb_sequencer dut (
    .pclk(pclk), .preset_n(preset_n), .start(start), .period(period),
    .auto_reload(auto_reload), .cancel(cancel), .busy(busy), .done(done),
    .irq(irq), .err(err),
`ifdef TIMER_SEQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // APB slave: decides pready/pslverr/prdata at the negedge, logs each completing transfer.
  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge pclk);
      if (done) done_cnt++;
      if (psel && penable && preset_n) begin
        cur_pen++;
        if (cur_pen > ready_delay) begin
          pready  = 1'b1;
          prdata  = (!pwrite && rd_vals.size() > 0) ? rd_vals.pop_front() : 32'h0;
          pslverr = (xfer_idx == err_idx);
          if (n_log < 64) begin
            lw[n_log] = pwrite;
            la[n_log] = paddr;
            ld[n_log] = pwrite ? pwdata : prdata;
            lp[n_log] = cur_pen;
            n_log++;
          end
          xfer_idx++;
        end else begin
          pready = 1'b0; pslverr = 1'b0;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; cur_pen = 0;
      end
    end
  end

  function automatic logic [64:0] ent(input logic wr, input logic [31:0] a, input logic [31:0] d);
    return {wr, a, d};
  endfunction

  task automatic clear_log();
    for (int i = 0; i < 64; i++) begin
      lw[i] = 1'b0; la[i] = '1; ld[i] = '1; lp[i] = 0;
    end
    n_log = 0; xfer_idx = 0; done_cnt = 0; err_idx = -1; ready_delay = 0;
    rd_vals.delete();
  endtask

  task automatic do_start(input logic [31:0] p, input logic ar);
    @(negedge pclk);
    start = 1'b1; period = p; auto_reload = ar;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0; start = 1'b0; period = '0; auto_reload = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge pclk);
    n_tests++;
    if ({busy, done, irq, err, psel, penable, pwrite} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {busy, done, irq, err, psel, penable, pwrite});
    end
    n_tests++;
    if ({paddr, pwdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0", {paddr, pwdata});
    end
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);
    n_tests++;
    if ({busy, psel} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: got %b expected 00", {busy, psel});
    end
  endtask

  task automatic test_one_shot();
    logic [64:0] exp[8];
    bit ok;
    clear_log();
    rd_vals = '{32'h0, 32'h0, 32'h2};
    exp = '{ent(1, 32'h0, 32'hFF), ent(0, 32'h8, 32'h0), ent(1, 32'h4, 32'h80), ent(1, 32'h4, 32'h30),
            ent(0, 32'h8, 32'h0), ent(0, 32'h8, 32'h2), ent(1, 32'h8, 32'h3), ent(1, 32'h4, 32'h0)};
    do_start(32'hFF, 1'b0);
    wait_idle(2000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL one_shot_idle: busy still %b expected 0", busy); end
    n_tests++;
    if (n_log !== 8) begin n_fail++; $display("FAIL one_shot_count: got %0d expected 8", n_log); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ent(lw[i], la[i], ld[i]) !== exp[i]) begin
        n_fail++; $display("FAIL one_shot_xfer%0d: got %h expected %h", i, ent(lw[i], la[i], ld[i]), exp[i]);
      end
    end
    n_tests++;
    if (lp[0] !== 1) begin n_fail++; $display("FAIL one_shot_penable: got %0d expected 1", lp[0]); end
    n_tests++;
    if ({done_cnt, irq, err} !== {32'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL one_shot_flags: done=%0d irq=%b err=%b expected 1 1 0", done_cnt, irq, err);
    end
  endtask

  task automatic test_stale_flag();
    logic [64:0] exp[8];
    bit ok;
    clear_log();
    rd_vals = '{32'h2, 32'h2};
    exp = '{ent(1, 32'h0, 32'h5), ent(0, 32'h8, 32'h2), ent(1, 32'h8, 32'h3), ent(1, 32'h4, 32'h80),
            ent(1, 32'h4, 32'h30), ent(0, 32'h8, 32'h2), ent(1, 32'h8, 32'h3), ent(1, 32'h4, 32'h0)};
    do_start(32'h5, 1'b0);
    wait_idle(2000, ok);
    n_tests++;
    if (!ok || n_log !== 8) begin n_fail++; $display("FAIL stale_count: idle=%b got %0d expected 8", ok, n_log); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ent(lw[i], la[i], ld[i]) !== exp[i]) begin
        n_fail++; $display("FAIL stale_xfer%0d: got %h expected %h", i, ent(lw[i], la[i], ld[i]), exp[i]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [64:0] exp[12];
    bit ok;
    clear_log();
    rd_vals = '{32'h0, 32'h2, 32'h0, 32'h2, 32'h2};
    exp = '{ent(1, 32'h0, 32'h40), ent(0, 32'h8, 32'h0), ent(1, 32'h4, 32'h80), ent(1, 32'h4, 32'h30),
            ent(0, 32'h8, 32'h2), ent(1, 32'h8, 32'h3), ent(0, 32'h8, 32'h0), ent(0, 32'h8, 32'h2),
            ent(1, 32'h8, 32'h3), ent(0, 32'h8, 32'h2), ent(1, 32'h8, 32'h3), ent(1, 32'h4, 32'h0)};
    do_start(32'h40, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk);
      if (done_cnt >= 3) break;
    end
    cancel = 1'b1;
    @(negedge pclk);
    cancel = 1'b0;
    wait_idle(2000, ok);
    n_tests++;
    if (!ok || n_log !== 12) begin n_fail++; $display("FAIL auto_count: idle=%b got %0d expected 12", ok, n_log); end
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (ent(lw[i], la[i], ld[i]) !== exp[i]) begin
        n_fail++; $display("FAIL auto_xfer%0d: got %h expected %h", i, ent(lw[i], la[i], ld[i]), exp[i]);
      end
    end
    n_tests++;
    if ({done_cnt, irq} !== {32'd3, 1'b0}) begin
      n_fail++; $display("FAIL auto_flags: done=%0d irq=%b expected 3 0", done_cnt, irq);
    end
  endtask

  task automatic test_wait_err();
    bit ok;
    clear_log();
    ready_delay = 4;
    err_idx = 2;
    rd_vals = '{32'h0};
    do_start(32'h10, 1'b0);
    wait_idle(2000, ok);
    n_tests++;
    if (!ok || lp[0] !== 5) begin n_fail++; $display("FAIL wait_penable: idle=%b got %0d expected 5", ok, lp[0]); end
    n_tests++;
    if ({err, busy, irq} !== 3'b100) begin
      n_fail++; $display("FAIL err_flags: got %b expected 100", {err, busy, irq});
    end
    repeat (40) @(negedge pclk);
    n_tests++;
    if (n_log !== 3 || psel !== 1'b0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL err_no_more: n=%0d psel=%b done=%0d expected 3 0 0", n_log, psel, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    ready_delay = 1000;
    do_start(32'h77, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (psel && penable) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_mid_access: never saw ACCESS, psel=%b", psel); end
    preset_n = 1'b0;
    #1;
    n_tests++;
    if ({psel, penable, busy, irq, err} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_clear: got %b expected 00000", {psel, penable, busy, irq, err});
    end
    @(negedge pclk);
    preset_n = 1'b1;
    clear_log();
    rd_vals = '{32'h0, 32'h2};
    do_start(32'h99, 1'b0);
    wait_idle(2000, ok);
    n_tests++;
    if (!ok || n_log !== 7 || ent(lw[0], la[0], ld[0]) !== ent(1, 32'h0, 32'h99)) begin
      n_fail++; $display("FAIL rst_mid_rerun: n=%0d first=%h expected 7 %h", n_log, ent(lw[0], la[0], ld[0]), ent(1, 32'h0, 32'h99));
    end
  endtask

  task automatic test_busy_start_ignored();
    bit ok;
    clear_log();
    rd_vals = '{32'h0, 32'h2};
    do_start(32'h0, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b expected 1", busy); end
    do_start(32'h1234, 1'b1);
    wait_idle(2000, ok);
    n_tests++;
    if (!ok || n_log !== 7 || ent(lw[0], la[0], ld[0]) !== ent(1, 32'h0, 32'h0)) begin
      n_fail++; $display("FAIL period_zero: n=%0d first=%h expected 7 %h", n_log, ent(lw[0], la[0], ld[0]), ent(1, 32'h0, 32'h0));
    end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL busy_irq: got %b expected 1", irq); end
  endtask

  task automatic test_cancel_idle();
    int n0;
    n0 = n_log;
    @(negedge pclk);
    cancel = 1'b1;
    @(negedge pclk);
    cancel = 1'b0;
    repeat (5) @(negedge pclk);
    n_tests++;
    if ({irq, busy} !== 2'b00 || n_log !== n0) begin
      n_fail++; $display("FAIL cancel_idle: irq=%b busy=%b n=%0d expected 0 0 %0d", irq, busy, n_log, n0);
    end
  endtask

`ifdef TIMER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int  pen;
    bit  seen, ok;
    clear_log();
    ready_delay = 100000;
    do_start(32'h1, 1'b0);
    pen = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk);
      if (psel && penable) begin pen++; seen = 1'b1; end
      else if (seen && !psel) break;
    end
    n_tests++;
    if (pen !== 255 || psel !== 1'b0) begin
      n_fail++; $display("FAIL timeout_len: got %0d psel=%b expected 255 0", pen, psel);
    end
    wait_idle(50, ok);
    n_tests++;
    if (!ok || {err, timeout} !== 2'b11) begin
      n_fail++; $display("FAIL timeout_flags: idle=%b err=%b timeout=%b expected 1 1", ok, err, timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_stale_flag();
    test_auto_reload();
    test_wait_err();
    test_reset_mid();
    test_busy_start_ignored();
    test_cancel_idle();
`ifdef TIMER_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
